baccarat_deal_ctrl: RTL and testbench

- Round sequencer for the baccarat datapath.
- Issues one-cycle load strobes to the six card registers in dealing order, then applies the natural and third-card rules.
- Decisions use the player and dealer scores from the two hand-scoring instances, plus the player's third card.
- Declares the round outcome and holds it until the next round is started.

---
 rtl/baccarat_pkg.sv | 35 +++
 rtl/baccarat_dealer_rule.sv | 33 +++
 rtl/baccarat_deal_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_baccarat_deal_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round sequencer.
//   deal_state_t : round sequencer states
//   NATURAL_MIN, PLAYER_STAND_MIN, DEALER_STAND, CARD_ZERO_MIN : rule thresholds
//   card_value() : maps a raw 4-bit card code to its point value
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_P1   = 4'd0,
        S_D1   = 4'd1,
        S_P2   = 4'd2,
        S_D2   = 4'd3,
        S_EVAL = 4'd4,
        S_P3   = 4'd5,
        S_DCHK = 4'd6,
        S_D3   = 4'd7,
        S_DONE = 4'd8
    } deal_state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] DEALER_STAND     = 4'd7;
    localparam logic [3:0] CARD_ZERO_MIN    = 4'd10;

    // Tens and court cards (codes 10..15) are worth zero points.
    function automatic logic [3:0] card_value(input logic [3:0] raw);
        logic [3:0] val;
        if (raw >= CARD_ZERO_MIN) begin
            val = 4'd0;
        end else begin
            val = raw;
        end
        return val;
    endfunction

endpackage

// File: rtl/baccarat_dealer_rule.sv
// Dealer third-card decision once the player has drawn a third card.
//   dscore : dealer two-card score, 0..9
//   pcard3 : raw player third card, 0..15 (10..15 count as 0)
//   draw   : 1 when the dealer must take a third card
module baccarat_dealer_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] t_s;

    // Dealer drawing table indexed by dealer score and player third-card value.
    always_comb begin
        t_s  = card_value(pcard3);
        draw = 1'b0;
        if (dscore >= DEALER_STAND) begin
            draw = 1'b0;
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (t_s != 4'd8);
                4'd4:             draw = (t_s >= 4'd2) && (t_s <= 4'd7);
                4'd5:             draw = (t_s >= 4'd4) && (t_s <= 4'd7);
                4'd6:             draw = (t_s >= 4'd6) && (t_s <= 4'd7);
                default:          draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat round sequencer: deals four cards with one-cycle load strobes,
// applies the natural and third-card rules, then latches and holds the
// outcome until the next advance starts a new round.
//   slow_clock, reset (async, active-high), advance (step request)
//   pscore, dscore  : hand scores from the scoring datapath
//   pcard3          : raw player third card
//   load_*          : card-register load strobes (Mealy, one cycle)
//   clear_cards     : zero all card registers at the start of a new round
//   player_win, dealer_win (both = tie), done : registered outcome
// Optional macro ROUND_TALLY_EN adds saturating player/dealer/tie tallies.
module baccarat_deal_ctrl
    import baccarat_pkg::*;
#(
    parameter int AUTO_ADVANCE = 0
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       advance,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_cards,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
`ifdef ROUND_TALLY_EN
    ,
    output logic [7:0] player_tally,
    output logic [7:0] dealer_tally,
    output logic [7:0] tie_tally
`endif
);

    deal_state_t state_r;
    deal_state_t next_state_s;
    logic        step_s;
    logic        dealer_draw_s;
    logic        latch_s;
    logic        player_win_r;
    logic        dealer_win_r;
    logic        done_r;

    // Strobes are gated by reset so nothing fires while the round is abandoned.
    assign step_s = ((AUTO_ADVANCE != 32'sd0) ? 1'b1 : advance) & ~reset;

    // The outcome is latched on the first clock spent in S_DONE, when the
    // scores already reflect any third card loaded on the entering edge.
    assign latch_s = (state_r == S_DONE) && !done_r;

    baccarat_dealer_rule u_dealer_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (dealer_draw_s)
    );

    // State register.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_r <= S_P1;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Mealy strobe decode.
    always_comb begin
        next_state_s = state_r;
        load_pcard1  = 1'b0;
        load_pcard2  = 1'b0;
        load_pcard3  = 1'b0;
        load_dcard1  = 1'b0;
        load_dcard2  = 1'b0;
        load_dcard3  = 1'b0;
        clear_cards  = 1'b0;
        case (state_r)
            S_P1: begin
                if (step_s) begin
                    load_pcard1  = 1'b1;
                    next_state_s = S_D1;
                end else begin
                    next_state_s = S_P1;
                end
            end
            S_D1: begin
                if (step_s) begin
                    load_dcard1  = 1'b1;
                    next_state_s = S_P2;
                end else begin
                    next_state_s = S_D1;
                end
            end
            S_P2: begin
                if (step_s) begin
                    load_pcard2  = 1'b1;
                    next_state_s = S_D2;
                end else begin
                    next_state_s = S_P2;
                end
            end
            S_D2: begin
                if (step_s) begin
                    load_dcard2  = 1'b1;
                    next_state_s = S_EVAL;
                end else begin
                    next_state_s = S_D2;
                end
            end
            S_EVAL: begin
                if (!step_s) begin
                    next_state_s = S_EVAL;
                end else if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                    next_state_s = S_DONE;
                end else if (pscore < PLAYER_STAND_MIN) begin
                    next_state_s = S_P3;
                end else if (dscore < PLAYER_STAND_MIN) begin
                    // Player stood on 6/7; dealer draws on 0..5.
                    next_state_s = S_D3;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_P3: begin
                if (step_s) begin
                    load_pcard3  = 1'b1;
                    next_state_s = S_DCHK;
                end else begin
                    next_state_s = S_P3;
                end
            end
            S_DCHK: begin
                if (!step_s) begin
                    next_state_s = S_DCHK;
                end else if (dealer_draw_s) begin
                    next_state_s = S_D3;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_D3: begin
                if (step_s) begin
                    load_dcard3  = 1'b1;
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_D3;
                end
            end
            S_DONE: begin
                // Advance is honoured only after the outcome has been latched.
                if (done_r && step_s) begin
                    clear_cards  = 1'b1;
                    next_state_s = S_P1;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: begin
                next_state_s = S_P1;
            end
        endcase
    end

    // Outcome flags: latched once per round, dropped when the next round starts.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            player_win_r <= 1'b0;
            dealer_win_r <= 1'b0;
            done_r       <= 1'b0;
        end else if (latch_s) begin
            player_win_r <= (pscore >= dscore);
            dealer_win_r <= (dscore >= pscore);
            done_r       <= 1'b1;
        end else if (clear_cards) begin
            player_win_r <= 1'b0;
            dealer_win_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            player_win_r <= player_win_r;
            dealer_win_r <= dealer_win_r;
            done_r       <= done_r;
        end
    end

    assign player_win = player_win_r;
    assign dealer_win = dealer_win_r;
    assign done       = done_r;

`ifdef ROUND_TALLY_EN
    logic [7:0] player_tally_r;
    logic [7:0] dealer_tally_r;
    logic [7:0] tie_tally_r;

    // Saturating per-outcome round counters, cleared only by reset.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            player_tally_r <= 8'd0;
            dealer_tally_r <= 8'd0;
            tie_tally_r    <= 8'd0;
        end else if (latch_s) begin
            if ((pscore > dscore) && (player_tally_r != 8'hFF)) begin
                player_tally_r <= player_tally_r + 8'd1;
            end else if ((dscore > pscore) && (dealer_tally_r != 8'hFF)) begin
                dealer_tally_r <= dealer_tally_r + 8'd1;
            end else if ((pscore == dscore) && (tie_tally_r != 8'hFF)) begin
                tie_tally_r <= tie_tally_r + 8'd1;
            end else begin
                player_tally_r <= player_tally_r;
            end
        end else begin
            player_tally_r <= player_tally_r;
        end
    end

    assign player_tally = player_tally_r;
    assign dealer_tally = dealer_tally_r;
    assign tie_tally    = tie_tally_r;
`endif

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Scoreboard bench for baccarat_deal_ctrl. The bench owns the six card
// registers and the hand scoring; a reference model plays each round from
// the dealt cards and queues the expected strobe/outcome sequence, which a
// negedge monitor consumes as the DUT produces it.
module tb_baccarat_deal_ctrl;

    logic       slow_clock = 1'b0;
    logic       reset;
    logic       advance;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clear_cards, player_win, dealer_win, done;
`ifdef ROUND_TALLY_EN
    logic [7:0] player_tally, dealer_tally, tie_tally;
`endif

    baccarat_deal_ctrl dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .advance     (advance),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .clear_cards (clear_cards),
        .player_win  (player_win),
        .dealer_win  (dealer_win),
        .done        (done)
`ifdef ROUND_TALLY_EN
        ,
        .player_tally (player_tally),
        .dealer_tally (dealer_tally),
        .tie_tally    (tie_tally)
`endif
    );

    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int errors = 0;
    int exp_q[$];          // 0..5 card strobes in deal order, 6 = clear, 8+{pw,dw} = outcome
    bit round_over;
    bit tb_clear;
    logic [3:0] deck [6];  // cards for the current round, in dealing order
    logic [3:0] pc [3];
    logic [3:0] dc [3];
    int model_pt = 0, model_dt = 0, model_tt = 0;

    function automatic int cv(input logic [3:0] raw);
        return (raw > 4'd9) ? 0 : int'(raw);
    endfunction

    // Bench-side card registers and hand scoring datapath.
    always @(posedge slow_clock) begin
        if (clear_cards || tb_clear) begin
            for (int i = 0; i < 3; i++) begin
                pc[i] <= 4'd0;
                dc[i] <= 4'd0;
            end
        end else begin
            if (load_pcard1) pc[0] <= deck[0];
            if (load_dcard1) dc[0] <= deck[1];
            if (load_pcard2) pc[1] <= deck[2];
            if (load_dcard2) dc[1] <= deck[3];
            if (load_pcard3) pc[2] <= deck[4];
            if (load_dcard3) dc[2] <= deck[5];
        end
    end

    assign pscore = 4'((cv(pc[0]) + cv(pc[1]) + cv(pc[2])) % 10);
    assign dscore = 4'((cv(dc[0]) + cv(dc[1]) + cv(dc[2])) % 10);
    assign pcard3 = pc[2];

    // Monitor: pop and compare whenever the DUT strobes or declares an outcome.
    logic [6:0] stb;
    assign stb = {clear_cards, load_dcard3, load_pcard3, load_dcard2,
                  load_pcard2, load_dcard1, load_pcard1};
    bit done_prev = 1'b0;
    bit clear_prev = 1'b0;
    int mon_e, mon_code;

    always @(negedge slow_clock) begin
        if (!reset) begin
            if (done && !done_prev) begin
                checks++;
                mon_code = 8 + (player_win ? 2 : 0) + (dealer_win ? 1 : 0);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL outcome: got code %0d, expected nothing", mon_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e != mon_code) begin
                        errors++;
                        $display("FAIL outcome: got code %0d (pw=%0b dw=%0b), expected %0d",
                                 mon_code, player_win, dealer_win, mon_e);
                    end
                end
            end
            if (clear_prev) begin
                checks++;
                if ({player_win, dealer_win, done} != 3'b000) begin
                    errors++;
                    $display("FAIL flags_drop: got pw/dw/done=%b, expected 000",
                             {player_win, dealer_win, done});
                end
            end
            if (!advance) begin
                checks++;
                if (stb != 7'd0) begin
                    errors++;
                    $display("FAIL stall_strobe: got strobes %b with advance=0, expected 0", stb);
                end
            end
            if (stb != 7'd0) begin
                checks++;
                mon_code = -1;
                for (int i = 0; i < 7; i++) if (stb[i]) mon_code = i;
                if ($countones(stb) != 1 || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe: got %b, expected queue depth %0d", stb, exp_q.size());
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e != mon_code) begin
                        errors++;
                        $display("FAIL strobe: got code %0d, expected %0d", mon_code, mon_e);
                    end
                end
                if (stb[6]) round_over = 1'b1;
            end
        end
        done_prev  = done;
        clear_prev = stb[6];
    end

    function automatic bit dealer_draws(input int d, input int t);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return t != 8;
            4:       return t >= 2 && t <= 7;
            5:       return t >= 4 && t <= 7;
            6:       return t >= 6 && t <= 7;
            default: return 1'b0;
        endcase
    endfunction

    // Reference round: queue the expected events, then drive advance.
    task automatic run_round(input bit rnd);
        int p, d;
        bit pw, dw;
        p = (cv(deck[0]) + cv(deck[2])) % 10;
        d = (cv(deck[1]) + cv(deck[3])) % 10;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        if (p >= 8 || d >= 8) begin
            // natural: no more cards
        end else if (p <= 5) begin
            exp_q.push_back(4);
            if (dealer_draws(d, cv(deck[4]))) begin
                exp_q.push_back(5);
                d = (d + cv(deck[5])) % 10;
            end
            p = (p + cv(deck[4])) % 10;
        end else if (d <= 5) begin
            exp_q.push_back(5);
            d = (d + cv(deck[5])) % 10;
        end
        pw = (p >= d);
        dw = (d >= p);
        if (pw && !dw) model_pt++;
        else if (dw && !pw) model_dt++;
        else model_tt++;
        exp_q.push_back(8 + (pw ? 2 : 0) + (dw ? 1 : 0));
        exp_q.push_back(6);
        round_over = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge slow_clock);
            #1;
            if (round_over) break;
            advance = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        advance = 1'b0;
        checks++;
        if (!round_over) begin
            errors++;
            $display("FAIL round_timeout: got no clear_cards, expected round end (queue %0d)",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_deck(input int a, b, c, d, e, f);
        deck[0] = 4'(a); deck[1] = 4'(b); deck[2] = 4'(c);
        deck[3] = 4'(d); deck[4] = 4'(e); deck[5] = 4'(f);
    endtask

    initial begin
        reset = 1'b1;
        advance = 1'b0;
        tb_clear = 1'b1;
        set_deck(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge slow_clock);
        #1;
        reset = 1'b0;
        tb_clear = 1'b0;
        checks++;
        if ({stb, player_win, dealer_win, done} != 10'd0) begin
            errors++;
            $display("FAIL reset_state: got strobes %b flags %b, expected all 0",
                     stb, {player_win, dealer_win, done});
        end

        // Deal four cards back to back, then reset while sitting in S_EVAL.
        set_deck(4, 2, 5, 3, 0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        advance = 1'b1;
        repeat (4) @(posedge slow_clock);
        #1;
        advance = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({stb, player_win, dealer_win, done} != 10'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_round: got strobes %b flags %b queue %0d, expected 0",
                     stb, {player_win, dealer_win, done}, exp_q.size());
        end
        exp_q.delete();
        tb_clear = 1'b1;
        @(posedge slow_clock);
        #1;
        reset = 1'b0;
        tb_clear = 1'b0;

        // Directed rounds with advance held high.
        set_deck(4, 2, 5, 3, 0, 0);   run_round(1'b0);  // natural 9 v 5
        set_deck(1, 1, 2, 2, 8, 5);   run_round(1'b0);  // P draws 8, dealer on 3 stands
        set_deck(3, 2, 3, 2, 0, 2);   run_round(1'b0);  // P stands 6, D draws to 6: tie
        set_deck(1, 2, 1, 2, 12, 5);  run_round(1'b0);  // face third card: D on 4 stands
        set_deck(1, 2, 1, 2, 7, 5);   run_round(1'b0);  // third card 7: D on 4 draws
        set_deck(1, 2, 1, 2, 7, 5);   run_round(1'b1);  // same with stalls

        // Randomized rounds with random stalls.
        for (int r = 0; r < 120; r++) begin
            for (int k = 0; k < 6; k++) deck[k] = 4'($urandom_range(0, 15));
            run_round(1'b1);
        end

`ifdef ROUND_TALLY_EN
        for (int r = 0; r < 260; r++) begin
            set_deck(4, 2, 5, 3, 0, 0);
            run_round(1'b0);
        end
        checks++;
        if (player_tally != 8'((model_pt > 255) ? 255 : model_pt) ||
            dealer_tally != 8'((model_dt > 255) ? 255 : model_dt) ||
            tie_tally    != 8'((model_tt > 255) ? 255 : model_tt)) begin
            errors++;
            $display("FAIL tally: got %0d/%0d/%0d, expected %0d/%0d/%0d (saturating)",
                     player_tally, dealer_tally, tie_tally, model_pt, model_dt, model_tt);
        end
`endif

        repeat (3) @(posedge slow_clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending events, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
